// File: rtl/demux_pkg.sv
// Shared defaults, routing classification and drop-counter saturation for demux_stream.
package demux_pkg;

  localparam int unsigned DEF_N_CH      = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_SEL_W     = 3;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam bit          DEF_ZERO_IDLE = 1'b1;

  // How an incoming word is routed this cycle.
  typedef enum logic [1:0] {
    ROUTE_UNI   = 2'd0,
    ROUTE_BCAST = 2'd1,
    ROUTE_DROP  = 2'd2
  } route_e;

  // Saturation value of a drop counter that is w bits wide (2**w - 1).
  function automatic int unsigned drop_sat(input int unsigned w);
    if (w >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot: full exactly when valid is high, refillable while draining.
module demux_slot #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          ZERO_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // Slot can take a word when empty or when its current word leaves this cycle.
  always_comb begin
    free = ~valid_r | ready;
  end

  // Slot register: reset wins, then load (also covers drain+load), then drain, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (load && free) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (ready) begin
      valid_r <= 1'b0;
      data_r  <= ZERO_IDLE ? {DATA_W{1'b0}} : data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each input word to one channel slot, to all slots
// (broadcast), or drops it when the select is out of range.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter bit          ZERO_IDLE = DEF_ZERO_IDLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(drop_sat(CNT_W));
  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);

  logic [N_CH-1:0]  free_s;
  logic [N_CH-1:0]  sel_oh_s;
  logic [N_CH-1:0]  load_s;
  route_e           route_s;
  logic             ready_s;
  logic             drop_s;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  // One-hot decode of the destination select.
  always_comb begin
    sel_oh_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_oh_s[i] = 1'b1;
      end else begin
        sel_oh_s[i] = 1'b0;
      end
    end
  end

  // Classify the word: broadcast overrides select; a select past the last channel is dropped.
  always_comb begin
    route_s = ROUTE_DROP;
    if (in_bcast) begin
      route_s = ROUTE_BCAST;
    end else if ({1'b0, in_sel} < N_CH_EXT) begin
      route_s = ROUTE_UNI;
    end else begin
      route_s = ROUTE_DROP;
    end
  end

  // Backpressure and slot load enables; dropped words are always accepted.
  always_comb begin
    ready_s = 1'b0;
    load_s  = {N_CH{1'b0}};
    drop_s  = 1'b0;
    case (route_s)
      ROUTE_UNI: begin
        ready_s = |(sel_oh_s & free_s);
        if (in_valid && ready_s) begin
          load_s = sel_oh_s;
        end else begin
          load_s = {N_CH{1'b0}};
        end
      end
      ROUTE_BCAST: begin
        ready_s = &free_s;
        load_s  = {N_CH{in_valid & ready_s}};
      end
      ROUTE_DROP: begin
        ready_s = 1'b1;
        drop_s  = in_valid;
      end
      default: begin
        ready_s = 1'b0;
        load_s  = {N_CH{1'b0}};
        drop_s  = 1'b0;
      end
    endcase
  end

  // Error pulse for one cycle per dropped word, plus a saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      err_r <= drop_s;
      if (drop_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_slot
      demux_slot #(
        .DATA_W    (DATA_W),
        .ZERO_IDLE (ZERO_IDLE)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s[g]),
        .load_data (in_data),
        .ready     (out_ready[g]),
        .valid     (out_valid[g]),
        .data      (out_data[g*DATA_W +: DATA_W]),
        .free      (free_s[g])
      );
    end
  endgenerate

  assign in_ready = ready_s;
  assign err_sel  = err_r;
  assign drop_cnt = cnt_r;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic,
// compared every cycle against a queue-based channel model.
module tb_demux_stream;

  localparam int N  = 6;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [SW-1:0]     in_sel;
  logic              in_bcast;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N*DW-1:0]   out_data;
  logic              err_sel;
  logic [CW-1:0]     drop_cnt;

  always #5 clk = ~clk;

  demux_stream #(
    .N_CH(N), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW), .ZERO_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: words waiting in each channel, drops seen, last-cycle error.
  logic [DW-1:0] mq [N][$];
  int            m_cnt = 0;
  bit            m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_free(input int c);
    return (mq[c].size() == 0) || (out_ready[c] == 1'b1);
  endfunction

  function automatic bit m_ready();
    bit all_free;
    all_free = 1'b1;
    for (int c = 0; c < N; c++) all_free &= m_free(c);
    if (in_bcast) return all_free;
    else if (int'(in_sel) < N) return m_free(int'(in_sel));
    else return 1'b1;
  endfunction

  task automatic drive(input bit v, input int sel, input bit bc, input logic [DW-1:0] d,
                       input logic [N-1:0] ordy);
    in_valid  = v;
    in_sel    = SW'(sel);
    in_bcast  = bc;
    in_data   = d;
    out_ready = ordy;
  endtask

  // One clock: check combinational ready, advance the model at the edge, check outputs.
  task automatic cyc();
    bit            rdy;
    bit            acc;
    logic [63:0]   exp_bus;
    logic [N-1:0]  exp_v;
    #1;
    rdy = m_ready();
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      for (int c = 0; c < N; c++)
        if (mq[c].size() > 0 && out_ready[c]) void'(mq[c].pop_front());
      m_err = 1'b0;
      if (acc) begin
        if (in_bcast) begin
          for (int c = 0; c < N; c++) mq[c].push_back(in_data);
        end else if (int'(in_sel) < N) begin
          mq[int'(in_sel)].push_back(in_data);
        end else begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    #1;
    exp_bus = '0;
    for (int c = 0; c < N; c++) begin
      exp_v[c] = (mq[c].size() > 0);
      if (mq[c].size() > 0) exp_bus[c*DW +: DW] = mq[c][0];
    end
    chk("out_valid", out_valid, exp_v);
    chk("out_data", out_data, exp_bus);
    chk("err_sel", err_sel, m_err);
    chk("drop_cnt", drop_cnt, m_cnt);
  endtask

  initial begin
    logic [63:0] e;

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, '1);
    cyc(); cyc();
    chk("rst_valid", out_valid, 6'h00);
    chk("rst_cnt", drop_cnt, 8'h00);
    rst = 1'b0;

    // Each select gets its own word, other lanes stay zero
    for (int i = 0; i < N; i++) begin
      drive(1, i, 0, 8'h10 + 8'(i), '1);
      cyc();
      e = '0;
      e[i*DW +: DW] = 8'h10 + 8'(i);
      chk("lane_one_hot", out_data, e);
    end
    drive(0, 0, 0, 8'h00, '1); cyc();

    // Stalled channel 2: first word holds, second waits, then follows
    drive(1, 2, 0, 8'hA1, 6'b111011); cyc();
    chk("stall_first", out_data[23:16], 8'hA1);
    drive(1, 2, 0, 8'hA2, 6'b111011);
    #1 chk("stall_ready_low", in_ready, 1'b0);
    cyc(); cyc();
    chk("stall_hold", out_data[23:16], 8'hA1);
    drive(1, 2, 0, 8'hA2, '1); cyc();
    chk("stall_release", out_data[23:16], 8'hA2);
    drive(0, 0, 0, 8'h00, '1); cyc();

    // Out-of-range selects are dropped and counted
    drive(1, 6, 0, 8'h55, '1);
    #1 chk("drop_ready", in_ready, 1'b1);
    cyc();
    chk("drop_err1", err_sel, 1'b1);
    drive(1, 7, 0, 8'h56, '1); cyc();
    chk("drop_err2", err_sel, 1'b1);
    drive(0, 0, 0, 8'h00, '1); cyc();
    chk("drop_err_off", err_sel, 1'b0);
    chk("drop_cnt2", drop_cnt, 8'd2);
    chk("drop_no_valid", out_valid, 6'h00);
    for (int k = 0; k < 300; k++) begin
      drive(1, 6 + (k % 2), 0, 8'($urandom), '1); cyc();
    end
    drive(0, 0, 0, 8'h00, '1); cyc();
    chk("drop_sat", drop_cnt, 8'd255);

    // Broadcast waits for a stalled slot 4, then fills every lane
    drive(1, 4, 0, 8'h44, 6'b101111); cyc();
    drive(1, 0, 1, 8'h3C, 6'b101111);
    #1 chk("bcast_blocked", in_ready, 1'b0);
    cyc(); cyc();
    drive(1, 0, 1, 8'h3C, '1); cyc();
    chk("bcast_data", out_data, {6{8'h3C}});
    chk("bcast_valid", out_valid, 6'h3F);
    drive(0, 0, 0, 8'h00, '1); cyc();

    // Back-to-back stream on channel 1
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 8'hB0 + 8'(k), '1); cyc();
      chk("stream_data", out_data[15:8], 8'hB0 + 8'(k));
      chk("stream_valid", out_valid[1], 1'b1);
    end
    drive(0, 0, 0, 8'h00, '1); cyc();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 9) == 0,
            8'($urandom), N'($urandom));
      cyc();
    end
    drive(0, 0, 0, 8'h00, '1); cyc();

    // Reset with full slots and a pending accept discards everything
    drive(1, 0, 0, 8'h71, '0); cyc();
    drive(1, 3, 0, 8'h73, '0); cyc();
    chk("pre_rst_valid", out_valid, 6'b001001);
    drive(1, 1, 0, 8'h99, '0);
    rst = 1'b1;
    cyc();
    chk("rst_mid_valid", out_valid, 6'h00);
    chk("rst_mid_cnt", drop_cnt, 8'h00);
    rst = 1'b0;
    drive(0, 0, 0, 8'h00, '0); cyc();
    chk("post_rst_valid", out_valid, 6'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 The block SHALL have these parameters:
  N_CH, 8, number of output channels (2..16)
  DATA_W, 8, payload width in bits
  SEL_W, 3, select width, with 2**SEL_W >= N_CH
  CNT_W, 8, width of the drop counter
  ZERO_IDLE, 1, 1 = out_data lane forced to 0 while its out_valid is low; 0 = lane holds its last value
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  input word present
  in_ready  out  1  block accepts input word this cycle
  in_data  in  DATA_W  input payload
  in_sel  in  SEL_W  destination channel index
  in_bcast  in  1  deliver word to all channels; in_sel is ignored
  out_valid  out  N_CH  per-channel word present
  out_ready  in  N_CH  per-channel consumer accepts
  out_data  out  N_CH*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
  err_sel  out  1  one-cycle pulse when an out-of-range select is dropped
  drop_cnt  out  CNT_W  saturating count of dropped words

Function
REQ-004 Each channel SHALL own a one-entry register slot; slot i is full exactly when out_valid[i]=1.
REQ-005 Slot i SHALL be "free" when out_valid[i]=0 or out_ready[i]=1 in the same cycle.
REQ-006 When in_bcast=0 and in_sel<N_CH, in_ready SHALL equal the free status of slot in_sel, combinationally.
REQ-007 When in_bcast=1, in_ready SHALL be 1 only when all N_CH slots are free.
REQ-008 When in_bcast=0 and in_sel>=N_CH, in_ready SHALL be 1; the word is dropped and not loaded into any slot.
REQ-009 An accept occurs when in_valid=1 and in_ready=1; the target slot(s) SHALL show out_valid=1 and the word on the following clock edge (latency 1 cycle).
REQ-010 A slot SHALL sustain one word per cycle: drain (out_ready=1) and load in the same cycle leaves out_valid=1 with the new word.
REQ-011 While out_valid[i]=1 and out_ready[i]=0, slot i's data and valid SHALL remain stable.
REQ-012 A slot drained with no new load SHALL clear out_valid[i] on the next edge.
REQ-013 When ZERO_IDLE=1, lane i SHALL read 0 whenever out_valid[i]=0.
REQ-014 Non-target slots SHALL be unaffected by an accept.
REQ-015 A dropped word SHALL raise err_sel for exactly the next cycle and increment drop_cnt by 1, saturating at 2**CNT_W-1.
REQ-016 Words SHALL never be duplicated, reordered within a channel, or lost, except under REQ-008.
REQ-017 All outputs except in_ready SHALL be registered.

Reset
REQ-018 On rst=1 at a clock edge: out_valid=0, all slot data=0, err_sel=0, drop_cnt=0.
REQ-019 Reset SHALL override any accept or drain in the same cycle; a word in flight at reset is discarded.
REQ-020 During rst=1, in_ready SHALL still follow REQ-006 to REQ-008, but no state SHALL change.

Structure
REQ-021 Parameter defaults and the drop-counter saturation constant SHALL live in a shared package/include, demux_pkg.
REQ-022 The one-entry slot SHALL be a sub-module, demux_slot (DATA_W, ZERO_IDLE), instantiated N_CH times by a generate loop.
REQ-023 Select decode, broadcast gating, and the error/counter logic SHALL reside in the top level.

Verification (N_CH=6, DATA_W=8, SEL_W=3, CNT_W=8, ZERO_IDLE=1)
REQ-024 Sel 0..5 with data 0x10..0x15, all out_ready=1 -> each lane shows its word one cycle later, and all other lanes read 0.
REQ-025 out_ready[2]=0; send 0xA1 then 0xA2 to sel 2 -> in_ready drops after the first word; 0xA1 holds; releasing out_ready[2] delivers 0xA2 on the next cycle.
REQ-026 Sel 6 with data 0x55, then sel 7 -> in_ready=1, no out_valid change, err_sel pulses twice, drop_cnt=2; 300 bad selects -> drop_cnt=255.
REQ-027 in_bcast=1 with data 0x3C while slot 4 is full and stalled -> in_ready=0; once out_ready[4]=1, all six lanes show 0x3C next cycle.
REQ-028 Back-to-back stream to sel 1 with out_ready[1]=1 for 10 cycles -> 10 words delivered in order, out_valid[1] continuously high.
REQ-029 Assert rst while slots 0 and 3 are full and an accept is pending -> next cycle out_valid=0, drop_cnt=0, and no word appears.
